// File: rtl/secret_pkg.sv
// Shared types for the secret accumulator result capture path.
package secret_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        CAPTURE,
        DRAIN
    } cap_state_t;

    localparam int OVF_W = 16;

endpackage

// File: rtl/secret_result_fifo.sv
// Synchronous DEPTH x word_t FIFO with a registered head word; a push is visible one cycle later.
// Push is refused when full unless a pop happens in the same cycle; pop on empty is a no-op.
module secret_result_fifo
    import secret_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    word_t       mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] rd_next;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = rd_ptr + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // The head register tracks the word at rd_next; if that slot is being
    // written this cycle the incoming word is taken directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            rd_ptr <= rd_next;
            if (do_push && (rd_next == wr_ptr)) begin
                head <= push_data;
            end else if (rd_next != wr_ptr) begin
                head <= mem[rd_next[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/secret_result_capture.sv
// Captures a fixed burst of accumulator results into a FIFO drained over valid/ready; optional XOR checksum under RESULT_CHECKSUM_EN.
// Words appear one cycle after capture; a full FIFO drops samples and counts them instead of stalling.
module secret_result_capture
    import secret_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SKIP_CYCLES = 2,
    parameter int CAPTURE_LEN = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      x_in,
    input  logic             x_valid,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [OVF_W-1:0] overflow_cnt
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    localparam logic [15:0] SKIP_LAST = 16'(SKIP_CYCLES - 1);
    localparam logic [15:0] CAP_LAST  = 16'(CAPTURE_LEN - 1);

    cap_state_t  state;
    cap_state_t  state_nxt;
    logic [15:0] skip_cnt;
    logic [15:0] sample_cnt;
    logic        full;
    logic        empty;
    logic        pop;
    logic        sample;
    logic        push;
    logic        drop;
    logic        clear;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign sample    = (state == CAPTURE) && x_valid;
    assign push      = sample && (!full || pop);
    assign drop      = sample && full && !pop;
    assign busy      = (state != IDLE);

    secret_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (x_in),
        .pop       (pop),
        .head      (out_data),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        clear     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = (SKIP_CYCLES == 0) ? CAPTURE : SKIP;
                end
            end
            SKIP: begin
                if (x_valid && (skip_cnt == SKIP_LAST)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (x_valid && (sample_cnt == CAP_LAST)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (empty && !push) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropped samples still advance sample_cnt so the burst length is fixed.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            skip_cnt     <= '0;
            sample_cnt   <= '0;
            overflow_cnt <= '0;
        end else begin
            if ((state == SKIP) && x_valid) begin
                skip_cnt <= skip_cnt + 16'd1;
            end
            if (sample) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
            if (drop && (overflow_cnt != {OVF_W{1'b1}})) begin
                overflow_cnt <= overflow_cnt + {{(OVF_W-1){1'b0}}, 1'b1};
            end
        end
    end

`ifdef RESULT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= checksum ^ x_in;
        end
    end
`endif

endmodule
